// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART slot numbering, data width and transmit state encoding
package uart_pkg;

  localparam logic [3:0] UART_SLOT_START = 4'd0;
  localparam logic [3:0] UART_SLOT_STOP  = 4'd9;
  localparam int         UART_DATA_W     = 8;

  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_SEND = 1'b1
  } uart_tx_state_e;

endpackage

// File: rtl/uart_baud_cnt.sv
// rtl/uart_baud_cnt.sv - baud divider with clear/enable; tick marks the last cycle of each bit slot
module uart_baud_cnt #(
  parameter int BAUD_DIV = 5208
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int CNT_W = $clog2(BAUD_DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BAUD_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Wraps to zero on its own so consecutive slots need no external clear.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/uart_tx_ctrl.sv
// rtl/uart_tx_ctrl.sv - UART transmit sequencer stepping tx_num over start/data/stop slots
// Define UART_TX_TWO_STOP_EN to hold the stop slot for two baud periods.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = 5208
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   tx_valid,
  input  logic [UART_DATA_W-1:0] tx_data,
  output logic                   tx_ready,
  output logic                   tx_sel_data,
  output logic [3:0]             tx_num,
  output logic [UART_DATA_W-1:0] tx_d,
  output logic                   tx_done
);

  if (BAUD_DIV < 2) begin : g_bad_baud_div
    $error("uart_tx_ctrl: BAUD_DIV must be at least 2");
  end

  uart_tx_state_e         state_q, state_d;
  logic                   ready_q, ready_d;
  logic                   sel_q, sel_d;
  logic [3:0]             num_q, num_d;
  logic [UART_DATA_W-1:0] txd_q, txd_d;
  logic                   done_q, done_d;
  logic                   baud_clr;
  logic                   baud_en;
  logic                   baud_tick;
  logic                   frame_end;
`ifdef UART_TX_TWO_STOP_EN
  logic                   stop_ext_q, stop_ext_d;
`endif

  uart_baud_cnt #(
    .BAUD_DIV(BAUD_DIV)
  ) u_baud_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (baud_clr),
    .en_i  (baud_en),
    .tick_o(baud_tick)
  );

  always_comb begin
    state_d   = state_q;
    ready_d   = ready_q;
    sel_d     = sel_q;
    num_d     = num_q;
    txd_d     = txd_q;
    done_d    = 1'b0;
    baud_clr  = 1'b0;
    baud_en   = 1'b0;
    frame_end = 1'b0;
`ifdef UART_TX_TWO_STOP_EN
    stop_ext_d = stop_ext_q;
`endif

    case (state_q)
      TX_IDLE: begin
        baud_clr = 1'b1;
        ready_d  = 1'b1;
        if (tx_valid && ready_q) begin
          txd_d   = tx_data;
          sel_d   = 1'b1;
          num_d   = UART_SLOT_START;
          ready_d = 1'b0;
          state_d = TX_SEND;
        end
      end
      TX_SEND: begin
        baud_en = 1'b1;
        if (baud_tick) begin
          if (num_q != UART_SLOT_STOP) begin
            num_d = num_q + 4'd1;
          end else begin
`ifdef UART_TX_TWO_STOP_EN
            // First stop period only arms the extension; the second ends the frame.
            stop_ext_d = ~stop_ext_q;
            frame_end  = stop_ext_q;
`else
            frame_end = 1'b1;
`endif
          end
        end
      end
      default: state_d = TX_IDLE;
    endcase

    if (frame_end) begin
      sel_d   = 1'b0;
      num_d   = UART_SLOT_START;
      ready_d = 1'b1;
      done_d  = 1'b1;
      state_d = TX_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= TX_IDLE;
      ready_q <= 1'b1;
      sel_q   <= 1'b0;
      num_q   <= UART_SLOT_START;
      txd_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      sel_q   <= sel_d;
      num_q   <= num_d;
      txd_q   <= txd_d;
      done_q  <= done_d;
    end
  end

`ifdef UART_TX_TWO_STOP_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stop_ext_q <= 1'b0;
    end else begin
      stop_ext_q <= stop_ext_d;
    end
  end
`endif

  assign tx_ready    = ready_q;
  assign tx_sel_data = sel_q;
  assign tx_num      = num_q;
  assign tx_d        = txd_q;
  assign tx_done     = done_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb/tb_uart_tx_ctrl.sv - self-checking bench for uart_tx_ctrl (BAUD_DIV=4 main, BAUD_DIV=2 minimum)
module tb_uart_tx_ctrl;

  localparam int B = 4;
`ifdef UART_TX_TWO_STOP_EN
  localparam int FRAME  = 44;
  localparam int FRAME2 = 22;
`else
  localparam int FRAME  = 40;
  localparam int FRAME2 = 20;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready, tx_sel_data, tx_done;
  logic [3:0] tx_num;
  logic [7:0] tx_d;

  logic       v2 = 1'b0;
  logic [7:0] d2 = 8'h00;
  logic       ready2, sel2, done2;
  logic [3:0] num2;
  logic [7:0] dd2;

  always #5 clk = ~clk;

  uart_tx_ctrl #(.BAUD_DIV(B)) dut (
    .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .tx_sel_data(tx_sel_data), .tx_num(tx_num),
    .tx_d(tx_d), .tx_done(tx_done)
  );

  uart_tx_ctrl #(.BAUD_DIV(2)) dut_min (
    .clk(clk), .rst(rst), .tx_valid(v2), .tx_data(d2),
    .tx_ready(ready2), .tx_sel_data(sel2), .tx_num(num2),
    .tx_d(dd2), .tx_done(done2)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a frame is just "cycles elapsed since the accepting edge".
  bit         m_busy = 1'b0;
  int         m_k = 0;
  logic [7:0] m_byte = 8'h00;
  bit         m_done = 1'b0;

  always @(posedge clk) begin
    m_done = 1'b0;
    if (rst) begin
      m_busy = 1'b0;
      m_k    = 0;
      m_byte = 8'h00;
    end else if (!m_busy) begin
      if (tx_valid) begin
        m_busy = 1'b1;
        m_k    = 0;
        m_byte = tx_data;
      end
    end else begin
      m_k++;
      if (m_k == FRAME) begin
        m_busy = 1'b0;
        m_k    = 0;
        m_done = 1'b1;
      end
    end
  end

  bit check_en = 1'b0;
  always @(negedge clk) begin
    if (check_en) begin
      logic [3:0] e_num;
      e_num = m_busy ? ((m_k / B > 9) ? 4'd9 : 4'(m_k / B)) : 4'd0;
      chk("cycle{ready,sel,num,d,done}", {17'd0, tx_ready, tx_sel_data, tx_num, tx_d, tx_done},
          {17'd0, !m_busy, m_busy, e_num, m_byte, m_done});
    end
  end

  int   hi_run = 0, lo_run = 0, last_hi = 0, last_gap = 0, done_cnt = 0;
  logic sel_prev = 1'b0;
  always @(posedge clk) begin
    if (tx_done === 1'b1) done_cnt++;
    if (tx_sel_data === 1'b1) begin
      if (!sel_prev) begin
        last_gap = lo_run;
        hi_run   = 0;
      end
      hi_run++;
    end else begin
      if (sel_prev) begin
        last_hi = hi_run;
        lo_run  = 0;
      end
      lo_run++;
    end
    sel_prev = (tx_sel_data === 1'b1);
  end

  // Output stage: one register behind tx_num, holds its value between frames.
  logic line_q = 1'b1;
  always @(posedge clk) begin
    if (rst) line_q <= 1'b1;
    else if (tx_sel_data) line_q <= (tx_num == 4'd0) ? 1'b0 : (tx_num >= 4'd9) ? 1'b1 : tx_d[tx_num - 1];
  end

  logic [9:0] cap = 10'h000;
  always @(negedge clk) begin
    if (m_busy && (m_k % B) == 2 && (m_k / B) <= 9) cap[m_k / B] = line_q;
  end

  task automatic send(input logic [7:0] b);
    int i;
    tx_valid = 1'b1;
    tx_data  = b;
    for (i = 0; i < 200 && tx_ready !== 1'b1; i++) @(negedge clk);
    if (tx_ready !== 1'b1) chk("send_timeout", 32'd0, 32'd1);
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_done();
    int i;
    for (i = 0; i < 200 && tx_done !== 1'b1; i++) @(negedge clk);
    if (tx_done !== 1'b1) chk("done_timeout", 32'd0, 32'd1);
    @(negedge clk);
  endtask

  task automatic wait_num(input logic [3:0] n);
    int i;
    for (i = 0; i < 200 && tx_num !== n; i++) @(negedge clk);
    if (tx_num !== n) chk("num_timeout", 32'd0, 32'd1);
  endtask

  typedef struct {
    logic [7:0] data;
    logic [9:0] line;
    int         gap;
  } vec_t;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[5];
    int   dc;
    int   q2[$];
    int   dc2;
    bit   ok;
    logic [7:0] b;

    vecs[0] = '{data: 8'hA5, line: 10'b1101001010, gap: 0};
    vecs[1] = '{data: 8'h00, line: 10'b1000000000, gap: 1};
    vecs[2] = '{data: 8'hFF, line: 10'b1111111110, gap: 3};
    vecs[3] = '{data: 8'h3C, line: 10'b1001111000, gap: 0};
    vecs[4] = '{data: 8'h81, line: 10'b1100000010, gap: 2};

    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_ready", tx_ready, 1);
    chk("reset_sel", tx_sel_data, 0);
    chk("reset_num", tx_num, 0);
    chk("reset_d", tx_d, 0);
    chk("reset_done", tx_done, 0);
    check_en = 1'b1;
    rst = 1'b0;

    // Minimum divider: frame length and slot order.
    v2 = 1'b1;
    d2 = 8'hC3;
    @(negedge clk);
    v2 = 1'b0;
    dc2 = 0;
    for (int i = 0; i < 40; i++) begin
      if (sel2 === 1'b1) q2.push_back(int'(num2));
      if (done2 === 1'b1) dc2++;
      @(negedge clk);
    end
    chk("min_frame_len", q2.size(), FRAME2);
    ok = 1'b1;
    foreach (q2[i]) if (q2[i] != ((i / 2 > 9) ? 9 : i / 2)) ok = 1'b0;
    chk("min_slot_order", ok, 1);
    chk("min_done_count", dc2, 1);
    chk("min_tx_d", dd2, 8'hC3);
    chk("min_idle_after", sel2, 0);

    for (int i = 0; i < 5; i++) begin
      repeat (vecs[i].gap) @(negedge clk);
      dc  = done_cnt;
      cap = ~vecs[i].line;
      send(vecs[i].data);
      chk("ready_fall", tx_ready, 0);
      wait_done();
      chk("line_bits", cap, vecs[i].line);
      chk("sel_high_len", last_hi, FRAME);
      chk("done_once", done_cnt - dc, 1);
    end

    // Back-to-back with tx_valid held through the done cycle.
    dc = done_cnt;
    tx_valid = 1'b1;
    tx_data  = 8'h00;
    @(negedge clk);
    tx_data = 8'hFF;
    chk("b2b_first_d", tx_d, 8'h00);
    for (int i = 0; i < 200 && tx_done !== 1'b1; i++) @(negedge clk);
    chk("b2b_done_seen", tx_done, 1);
    chk("b2b_ready_in_done", tx_ready, 1);
    chk("b2b_d_before_accept", tx_d, 8'h00);
    @(negedge clk);
    tx_valid = 1'b0;
    chk("b2b_second_start", tx_sel_data, 1);
    chk("b2b_second_d", tx_d, 8'hFF);
    wait_done();
    chk("b2b_gap", last_gap, 1);
    chk("b2b_done_count", done_cnt - dc, 2);

    // Mid-frame valid pulse is ignored.
    cap = 10'h000;
    send(8'h5A);
    wait_num(4'd5);
    tx_valid = 1'b1;
    tx_data  = 8'h3C;
    @(negedge clk);
    tx_valid = 1'b0;
    chk("mid_pulse_d", tx_d, 8'h5A);
    wait_done();
    chk("mid_pulse_line", cap, 10'b1010110100);
    dc = done_cnt;
    repeat (50) @(negedge clk);
    chk("mid_pulse_no_frame", tx_sel_data, 0);
    chk("mid_pulse_no_done", done_cnt - dc, 0);

    // Reset in slot 4 abandons the frame without tx_done.
    dc = done_cnt;
    send(8'h96);
    wait_num(4'd4);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_ready", tx_ready, 1);
    chk("rst_mid_sel", tx_sel_data, 0);
    chk("rst_mid_num", tx_num, 0);
    chk("rst_mid_done", tx_done, 0);
    repeat (50) @(negedge clk);
    chk("rst_mid_no_done", done_cnt - dc, 0);
    cap = 10'h000;
    send(8'h81);
    wait_done();
    chk("rst_after_line", cap, 10'b1100000010);
    chk("rst_after_done", done_cnt - dc, 1);

    // Reset and handshake together: reset wins.
    rst      = 1'b1;
    tx_valid = 1'b1;
    tx_data  = 8'hE7;
    @(negedge clk);
    rst      = 1'b0;
    tx_valid = 1'b0;
    chk("rst_hs_sel", tx_sel_data, 0);
    chk("rst_hs_d", tx_d, 8'h00);
    @(negedge clk);
    chk("rst_hs_still_idle", tx_sel_data, 0);

    for (int i = 0; i < 30; i++) begin
      b = 8'($urandom);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      cap = ~{1'b1, b, 1'b0};
      send(b);
      repeat ($urandom_range(1, 25)) @(negedge clk);
      tx_valid = 1'b1;
      tx_data  = 8'($urandom);
      @(negedge clk);
      tx_valid = 1'b0;
      wait_done();
      chk("rand_line", cap, {1'b1, b, 1'b0});
    end

    check_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
